// File: rtl/axil_mgr_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite manager port between NUM_REQ
// register-access requesters, running one single-beat transaction at a time.
module axil_mgr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    // requester side
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
    // AXI4-Lite manager
    output logic [ADDR_WIDTH-1:0]         awaddr,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic [ADDR_WIDTH-1:0]         araddr,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [DATA_WIDTH-1:0]         rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        last_gnt_q, last_gnt_d;
    logic [IDW-1:0]        gnt_id_q, gnt_id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;

    logic                  win_found;
    logic [IDW-1:0]        win_idx;
    logic                  grant;

    // Index (base + off) modulo NUM_REQ; base < NUM_REQ and off <= NUM_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDW'(sum);
    endfunction

    // Round-robin search starting just above the last winner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[wrap_add(last_gnt_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(last_gnt_q, k);
            end
        end
    end

    assign grant = win_found && (state_q == IDLE);

    // FSM: state register
    always_ff @(posedge aclk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block only.
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = req_write[win_idx] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // a channel is done once its valid has dropped or handshakes now
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_d = RESP;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs decoded from the current state
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state_q != IDLE);
        if (grant && !areset) begin
            req_ready[win_idx] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid[gnt_id_q] = 1'b1;
        end
    end

    // Datapath next-state: request capture, registered AXI controls, response capture.
    always_comb begin
        last_gnt_d  = last_gnt_q;
        gnt_id_d    = gnt_id_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = (state_d == WR_RESP);
        rready_d    = (state_d == RD_DATA);
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    last_gnt_d = win_idx;
                    gnt_id_d   = win_idx;
                    addr_d     = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d    = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    awvalid_d  = req_write[win_idx];
                    wvalid_d   = req_write[win_idx];
                    arvalid_d  = !req_write[win_idx];
                end
            end
            WR_ADDR_DATA: begin
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
            end
            WR_RESP: begin
                if (bvalid) begin
                    rsp_resp_d  = bresp;
                    rsp_rdata_d = '0;
                end
            end
            RD_ADDR: begin
                arvalid_d = !arready;
            end
            RD_DATA: begin
                if (rvalid) begin
                    rsp_resp_d  = rresp;
                    rsp_rdata_d = rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_gnt_q  <= IDW'(NUM_REQ - 1);
            gnt_id_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments.
            last_gnt_q  <= last_gnt_d;
            gnt_id_q    <= gnt_id_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign gnt_id    = gnt_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign arvalid   = arvalid_q;
    assign bready    = bready_q;
    assign rready    = rready_q;

endmodule

// File: tb/tb_axil_mgr_arbiter.sv
// Directed bench for axil_mgr_arbiter: a small AXI4-Lite subordinate with
// programmable stalls, and one task per scenario with inline comparisons.
module tb_axil_mgr_arbiter;

    logic         aclk = 1'b0;
    logic         areset;
    logic [3:0]   req_valid, req_ready, req_write, rsp_valid;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  rsp_rdata;
    logic [1:0]   rsp_resp;
    logic         busy;
    logic [1:0]   gnt_id;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;

    int checks   = 0;
    int failures = 0;

    // subordinate configuration and bookkeeping
    int          aw_delay = 0;
    int          r_delay  = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    int          aw_wait, r_wait;
    bit          have_aw, have_w, rd_pending;
    logic [31:0] wr_addr, wr_data, rd_addr;
    int          aw_hs_cnt = 0;
    int          w_hs_cnt  = 0;
    int          b_hs_cnt  = 0;
    int          rsp_cnt [4] = '{0, 0, 0, 0};
    logic [31:0] mem [logic [31:0]];

    axil_mgr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .busy(busy), .gnt_id(gnt_id),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    // Subordinate: handshakes are sampled at the edge, responses driven 1 time unit later.
    initial begin : subordinate
        logic s_rst, s_aw, s_w, s_b, s_ar, s_r;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_wait = 0; r_wait = 0; have_aw = 0; have_w = 0; rd_pending = 0;
        wr_addr = 0; wr_data = 0; rd_addr = 0;
        forever begin
            @(posedge aclk);
            s_rst = areset;
            s_aw = awvalid && awready;  s_awaddr = awaddr;
            s_w  = wvalid && wready;    s_wdata  = wdata;
            s_b  = bvalid && bready;
            s_ar = arvalid && arready;  s_araddr = araddr;
            s_r  = rvalid && rready;
            #1;
            if (s_rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_wait = 0; r_wait = 0; have_aw = 0; have_w = 0; rd_pending = 0;
            end else begin
                if (s_aw) begin have_aw = 1; wr_addr = s_awaddr; aw_hs_cnt++; aw_wait = 0; end
                if (s_w)  begin have_w = 1; wr_data = s_wdata; w_hs_cnt++; end
                if (s_b)  begin bvalid = 0; b_hs_cnt++; end
                if (s_ar) begin rd_pending = 1; rd_addr = s_araddr; r_wait = 0; end
                if (s_r)  rvalid = 0;
                if (have_aw && have_w && !bvalid) begin
                    mem[wr_addr] = wr_data;
                    bvalid = 1; bresp = cfg_bresp;
                    have_aw = 0; have_w = 0;
                end
                if (rd_pending) begin
                    if (r_wait >= r_delay) begin
                        rvalid = 1;
                        rdata  = mem.exists(rd_addr) ? mem[rd_addr] : 32'h0;
                        rresp  = cfg_rresp;
                        rd_pending = 0;
                    end else begin
                        r_wait++;
                    end
                end
                if (awvalid && !have_aw) begin
                    awready = (aw_wait >= aw_delay);
                    if (!awready) aw_wait++;
                end else begin
                    awready = 0;
                end
                wready  = wvalid && !have_w;
                arready = arvalid && !rd_pending;
            end
        end
    end

    // Completion pulse counter (pre-edge values).
    initial begin : rsp_monitor
        forever begin
            @(posedge aclk);
            for (int i = 0; i < 4; i++) begin
                if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_write[i]        = wr;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic wait_grant(input int budget, output logic [3:0] seen);
        seen = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge aclk);
            if (req_ready != 4'b0) begin
                seen = req_ready;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(input int budget, output logic [3:0] seen);
        seen = '0;
        for (int k = 0; k < budget; k++) begin
            @(negedge aclk);
            if (rsp_valid != 4'b0) begin
                seen = rsp_valid;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge aclk);
            if (!busy) break;
            tick();
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        req_valid = 4'b1111;
        repeat (3) tick();
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, busy} !== 6'b0) begin
            failures++;
            $display("FAIL rst_ctrl: {aw,w,ar,b,r,busy}=%b expected 000000",
                     {awvalid, wvalid, arvalid, bready, rready, busy});
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid);
        end
        checks++;
        if ({gnt_id, rsp_resp, rsp_rdata} !== 36'h0) begin
            failures++; $display("FAIL rst_regs: gnt_id=%h rsp_resp=%h rsp_rdata=%h expected 0",
                                 gnt_id, rsp_resp, rsp_rdata);
        end
        tick();
        req_valid = 4'b0000;
        areset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 32'h04, 32'hDEADBEEF);
        req_valid = 4'b0001;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL wr_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid, busy} !== 3'b111) begin
            failures++; $display("FAIL wr_c1_valids: {aw,w,busy}=%b expected 111", {awvalid, wvalid, busy});
        end
        checks++;
        if (awaddr !== 32'h04 || wdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_c1_payload: awaddr=%h wdata=%h expected 00000004 deadbeef", awaddr, wdata);
        end
        checks++;
        if (gnt_id !== 2'd0) begin
            failures++; $display("FAIL wr_gnt_id: got %0d expected 0", gnt_id);
        end
        tick();
        @(negedge aclk);
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin
            failures++; $display("FAIL wr_c2: {aw,w,bready}=%b expected 001", {awvalid, wvalid, bready});
        end
        tick();
        @(negedge aclk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL wr_c3_rsp: rsp_valid=%b resp=%b rdata=%h expected 0001 00 0",
                                 rsp_valid, rsp_resp, rsp_rdata);
        end
        tick();
        @(negedge aclk);
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            failures++; $display("FAIL wr_c4_idle: rsp_valid=%b busy=%b expected 0000 0", rsp_valid, busy);
        end
        tick();
    endtask

    task automatic test_read_back();
        set_req(0, 1'b0, 32'h04, 32'h0);
        req_valid = 4'b0001;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL rd_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        @(negedge aclk);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h04 || awvalid !== 1'b0) begin
            failures++; $display("FAIL rd_c1: arvalid=%b araddr=%h awvalid=%b expected 1 00000004 0",
                                 arvalid, araddr, awvalid);
        end
        tick();
        @(negedge aclk);
        checks++;
        if ({arvalid, rready} !== 2'b01) begin
            failures++; $display("FAIL rd_c2: {arvalid,rready}=%b expected 01", {arvalid, rready});
        end
        tick();
        @(negedge aclk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hDEADBEEF || rsp_resp !== 2'b00) begin
            failures++; $display("FAIL rd_c3_rsp: rsp_valid=%b rdata=%h resp=%b expected 0001 deadbeef 00",
                                 rsp_valid, rsp_rdata, rsp_resp);
        end
        tick();
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || rsp_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_c4_hold: busy=%b rsp_valid=%b rdata=%h expected 0 0000 deadbeef",
                                 busy, rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] seen;
        int exp_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_b [2] = '{1, 3};
        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h100 + 32'(i * 16), 32'h0);
        req_valid = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            wait_grant(20, seen);
            checks++;
            if (seen !== 4'(1 << exp_a[g])) begin
                failures++; $display("FAIL cont_order[%0d]: req_ready=%b expected %b", g, seen, 4'(1 << exp_a[g]));
            end
            tick();
            @(negedge aclk);
            checks++;
            if (gnt_id !== 2'(exp_a[g])) begin
                failures++; $display("FAIL cont_gnt_id[%0d]: got %0d expected %0d", g, gnt_id, exp_a[g]);
            end
            tick();
            if (g == 7) req_valid = 4'b1010;
        end
        for (int g = 0; g < 2; g++) begin
            wait_grant(20, seen);
            checks++;
            if (seen !== 4'(1 << exp_b[g])) begin
                failures++; $display("FAIL cont_sparse[%0d]: req_ready=%b expected %b", g, seen, 4'(1 << exp_b[g]));
            end
            tick();
            if (g == 1) req_valid = 4'b0000;
        end
        wait_idle(20);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL cont_drain: busy=%b expected 0", busy);
        end
        tick();
    endtask

    task automatic test_split_handshake();
        logic [2:0] exp_v [5] = '{3'b110, 3'b100, 3'b100, 3'b100, 3'b001};
        int aw0, w0, b0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        aw_delay  = 3;
        cfg_bresp = 2'b00;
        set_req(2, 1'b1, 32'h20, 32'hA5A50F0F);
        req_valid = 4'b0100;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL split_grant: req_ready=%b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            checks++;
            if ({awvalid, wvalid, bready} !== exp_v[c]) begin
                failures++; $display("FAIL split_c%0d: {aw,w,bready}=%b expected %b",
                                     c + 1, {awvalid, wvalid, bready}, exp_v[c]);
            end
            tick();
        end
        @(negedge aclk);
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_resp !== 2'b00) begin
            failures++; $display("FAIL split_rsp: rsp_valid=%b resp=%b expected 0100 00", rsp_valid, rsp_resp);
        end
        tick();
        @(negedge aclk);
        checks++;
        if (rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL split_pulse: rsp_valid=%b expected 0000", rsp_valid);
        end
        checks++;
        if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1 || b_hs_cnt - b0 !== 1) begin
            failures++; $display("FAIL split_once: aw=%0d w=%0d b=%0d handshakes expected 1 1 1",
                                 aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0);
        end
        aw_delay = 0;
        tick();
    endtask

    task automatic test_error_response();
        logic [3:0] seen;
        int c1;
        c1 = rsp_cnt[1];
        cfg_rresp = 2'b10;
        set_req(1, 1'b0, 32'hFF0, 32'h0);
        req_valid = 4'b0010;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL err_grant: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        wait_rsp(10, seen);
        checks++;
        if (seen !== 4'b0010 || rsp_resp !== 2'b10) begin
            failures++; $display("FAIL err_rsp: rsp_valid=%b resp=%b expected 0010 10", seen, rsp_resp);
        end
        tick();
        cfg_rresp = 2'b00;
        @(negedge aclk);
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_cnt[1] - c1 !== 1) begin
            failures++; $display("FAIL err_pulse: rsp_valid=%b pulses=%0d expected 0000 1", rsp_valid, rsp_cnt[1] - c1);
        end
        tick();
        set_req(3, 1'b1, 32'h08, 32'h12345678);
        req_valid = 4'b1000;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL err_next_grant: req_ready=%b expected 1000", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        wait_rsp(10, seen);
        checks++;
        if (seen !== 4'b1000 || rsp_resp !== 2'b00) begin
            failures++; $display("FAIL err_next_rsp: rsp_valid=%b resp=%b expected 1000 00", seen, rsp_resp);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] seen;
        int c0;
        c0 = rsp_cnt[0];
        r_delay = 5;
        set_req(0, 1'b0, 32'h04, 32'h0);
        req_valid = 4'b0001;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL mid_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        @(negedge aclk);
        checks++;
        if (arvalid !== 1'b1) begin
            failures++; $display("FAIL mid_arvalid: got %b expected 1", arvalid);
        end
        tick();
        @(negedge aclk);
        checks++;
        if ({rready, busy} !== 2'b11) begin
            failures++; $display("FAIL mid_rd_data: {rready,busy}=%b expected 11", {rready, busy});
        end
        tick();
        areset = 1'b1;
        tick();
        areset  = 1'b0;
        r_delay = 0;
        @(negedge aclk);
        checks++;
        if ({arvalid, rready, busy} !== 3'b000 || rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL mid_reset: {ar,rready,busy}=%b rsp_valid=%b expected 000 0000",
                                 {arvalid, rready, busy}, rsp_valid);
        end
        repeat (6) tick();
        @(negedge aclk);
        checks++;
        if (rsp_cnt[0] - c0 !== 0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_no_rsp: pulses=%0d busy=%b expected 0 0", rsp_cnt[0] - c0, busy);
        end
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h04, 32'h0);
        req_valid = 4'b1111;
        @(negedge aclk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL mid_first_after_reset: req_ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        wait_rsp(10, seen);
        checks++;
        if (seen !== 4'b0001 || rsp_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL mid_recover: rsp_valid=%b rdata=%h expected 0001 deadbeef", seen, rsp_rdata);
        end
        tick();
    endtask

    initial begin
        areset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_split_handshake();
        test_error_response();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
